// File: rtl/alu_rs_param.sv
// rtl/alu_rs_param.sv - ALU reservation station: CDB wakeup, oldest-ready issue, single result port.
// Optional flush input is enabled with `define ALU_RS_FLUSH_EN.
module alu_rs_param #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int N_CDB = 2,
    parameter int OP_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [OP_W-1:0]           disp_op,
    input  logic [TAG_W-1:0]          disp_dest,
    input  logic [TAG_W-1:0]          disp_tag1,
    input  logic [TAG_W-1:0]          disp_tag2,
    input  logic [XLEN-1:0]           disp_data1,
    input  logic [XLEN-1:0]           disp_data2,
    input  logic [N_CDB-1:0]          cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [N_CDB*XLEN-1:0]     cdb_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [TAG_W-1:0]          res_tag,
    output logic [XLEN-1:0]           res_data,
    output logic [$clog2(DEPTH+1)-1:0] free_cnt
`ifdef ALU_RS_FLUSH_EN
    ,
    input  logic                      flush
`endif
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int FREE_W = $clog2(DEPTH+1);
    localparam int SH_W   = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLTU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(10);

`ifndef ALU_RS_FLUSH_EN
    logic flush;
    assign flush = 1'b0;
`endif

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } opnd_t;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] older_q [DEPTH];   // older_q[i][j]: entry i was dispatched before entry j
    logic [OP_W-1:0]  op_q    [DEPTH];
    logic [TAG_W-1:0] dest_q  [DEPTH];
    opnd_t            opnd1_q [DEPTH];
    opnd_t            opnd2_q [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] oldest;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic [IDX_W-1:0] free_idx;
    logic             do_disp;
    logic             do_issue;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_res;
    logic [SH_W-1:0]  shamt;

    // Descending scan so the lowest matching port has the final say.
    function automatic opnd_t snoop(input opnd_t o);
        opnd_t r;
        r = o;
        if (o.tag != '0) begin
            for (int k = N_CDB-1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == o.tag) begin
                    r.tag  = '0;
                    r.data = cdb_data[k*XLEN +: XLEN];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        free_cnt = '0;
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_cnt = free_cnt + FREE_W'(1);
                free_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready = (free_cnt != '0);
    assign do_disp    = disp_valid && disp_ready && (disp_op != OP_NOP) && !flush;

    always_comb begin
        ready   = '0;
        oldest  = '0;
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] && (opnd1_q[i].tag == '0) && (opnd2_q[i].tag == '0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_q[j][i]) oldest[i] = 1'b0;
            end
            if (oldest[i]) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign do_issue = sel_any && (!res_valid || res_ready) && !flush;
    assign alu_a    = opnd1_q[sel_idx].data;
    assign alu_b    = opnd2_q[sel_idx].data;
    assign shamt    = alu_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op_q[sel_idx])
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            OP_SLL:  alu_res = alu_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
            OP_XOR:  alu_res = alu_a ^ alu_b;
            OP_SRL:  alu_res = alu_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(alu_a) >>> shamt);
            OP_OR:   alu_res = alu_a | alu_b;
            OP_AND:  alu_res = alu_a & alu_b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
        end else begin
            if (do_issue) valid_q[sel_idx] <= 1'b0;
            if (do_disp) begin
                valid_q[free_idx] <= 1'b1;
                // Column first, then row, so the self bit ends up cleared.
                for (int j = 0; j < DEPTH; j++) older_q[j][free_idx] <= 1'b1;
                older_q[free_idx] <= '0;
            end
            if (flush) valid_q <= '0;

            if (flush) begin
                res_valid <= 1'b0;
            end else if (do_issue) begin
                res_valid <= 1'b1;
                res_tag   <= dest_q[sel_idx];
                res_data  <= alu_res;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            opnd1_q[i] <= snoop(opnd1_q[i]);
            opnd2_q[i] <= snoop(opnd2_q[i]);
        end
        if (do_disp) begin
            op_q[free_idx]    <= disp_op;
            dest_q[free_idx]  <= disp_dest;
            opnd1_q[free_idx] <= snoop(opnd_t'({disp_tag1, disp_data1}));
            opnd2_q[free_idx] <= snoop(opnd_t'({disp_tag2, disp_data2}));
        end
    end
endmodule

// File: tb/tb_alu_rs_param.sv
// tb/tb_alu_rs_param.sv - scoreboard bench for alu_rs_param with default parameters.
module tb_alu_rs_param;
    localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, XOR = 4'd6, SRA = 4'd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_valid;
    logic        disp_ready;
    logic [3:0]  disp_op;
    logic [4:0]  disp_dest, disp_tag1, disp_tag2;
    logic [31:0] disp_data1, disp_data2;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_tag;
    logic [31:0] res_data;
    logic [3:0]  free_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [36:0] exp_q[$];

    alu_rs_param dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_dest(disp_dest), .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
        .disp_data1(disp_data1), .disp_data2(disp_data2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
        .res_data(res_data), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  return a << b[4:0];
            4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return a ^ b;
            4'd7:  return a >> b[4:0];
            4'd8:  return $unsigned($signed(a) >>> b[4:0]);
            4'd9:  return a | b;
            4'd10: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Handshake completes at the next rising edge; compare mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL result_unexpected got tag=%0d data=%h required none", res_tag, res_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({res_tag, res_data} !== e) begin
                    miscompares++;
                    $display("FAIL result got tag=%0d data=%h required tag=%0d data=%h",
                             res_tag, res_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic [4:0] dest, input logic [4:0] t1,
                        input logic [4:0] t2, input logic [31:0] d1, input logic [31:0] d2);
        disp_valid = 1'b1; disp_op = op; disp_dest = dest;
        disp_tag1 = t1; disp_tag2 = t2; disp_data1 = d1; disp_data2 = d2;
    endtask

    task automatic idle();
        disp_valid = 1'b0; disp_op = 4'd0;
        cdb_valid = 2'b00;
    endtask

    task automatic bcast(input int port, input logic [4:0] tag, input logic [31:0] data);
        cdb_valid[port] = 1'b1;
        cdb_tag[port*5 +: 5] = tag;
        cdb_data[port*32 +: 32] = data;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; res_ready = 1'b1; cdb_tag = '0; cdb_data = '0;
        disp_dest = '0; disp_tag1 = '0; disp_tag2 = '0; disp_data1 = '0; disp_data2 = '0;
        idle();
        step(); step();
        vectors += 5;
        if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got=%b required=0", res_valid); end
        if (res_tag !== 5'd0)   begin miscompares++; $display("FAIL reset_res_tag got=%0d required=0", res_tag); end
        if (res_data !== 32'd0) begin miscompares++; $display("FAIL reset_res_data got=%h required=0", res_data); end
        if (free_cnt !== 4'd8)  begin miscompares++; $display("FAIL reset_free_cnt got=%0d required=8", free_cnt); end
        if (disp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_disp_ready got=%b required=1", disp_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        disp(ADD, 5'd9, 5'd0, 5'd0, 32'd7, 32'hFFFF_FFFF);
        exp_q.push_back({5'd9, 32'd6});
        step();
        idle();
        vectors++;
        if (res_valid !== 1'b0) begin miscompares++; $display("FAIL add_latency_early got=%b required=0", res_valid); end
        step();
        vectors += 3;
        if (res_valid !== 1'b1) begin miscompares++; $display("FAIL add_res_valid got=%b required=1", res_valid); end
        if (res_data !== 32'd6) begin miscompares++; $display("FAIL add_res_data got=%h required=6", res_data); end
        if (res_tag !== 5'd9)   begin miscompares++; $display("FAIL add_res_tag got=%0d required=9", res_tag); end
        drain("add");
    endtask

    task automatic test_cdb_wakeup();
        disp(SUB, 5'd10, 5'd3, 5'd0, 32'd0, 32'd5);
        exp_q.push_back({5'd10, 32'd7});
        step();
        idle();
        bcast(1, 5'd3, 32'd12);
        step();
        idle();
        vectors++;
        if (res_valid !== 1'b0) begin miscompares++; $display("FAIL wake_early got=%b required=0", res_valid); end
        step();
        vectors += 2;
        if (res_valid !== 1'b1) begin miscompares++; $display("FAIL wake_res_valid got=%b required=1", res_valid); end
        if (res_data !== 32'd7) begin miscompares++; $display("FAIL wake_res_data got=%h required=7", res_data); end
        drain("wake");
    endtask

    task automatic test_bypass();
        disp(SRA, 5'd11, 5'd4, 5'd0, 32'd0, 32'd31);
        bcast(0, 5'd4, 32'h8000_0000);
        bcast(1, 5'd4, 32'h0000_0001);
        exp_q.push_back({5'd11, 32'hFFFF_FFFF});
        step();
        idle();
        step();
        vectors++;
        if (res_data !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL bypass_res_data got=%h required=ffffffff", res_data); end
        drain("bypass");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 24; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(1, 15));
            a = $urandom;
            b = (k % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            vectors++;
            if (disp_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_disp_ready k=%0d got=%b required=1", k, disp_ready); end
            disp(op, 5'(k % 30 + 1), 5'd0, 5'd0, a, b);
            exp_q.push_back({5'(k % 30 + 1), model(op, a, b)});
            step();
            if (k > 0) begin
                vectors++;
                if (res_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_throughput k=%0d got=%b required=1", k, res_valid); end
            end
        end
        idle();
        drain("b2b");
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            disp(ADD, 5'(i + 1), 5'(20 + i), 5'd0, 32'd0, 32'(i));
            step();
        end
        idle();
        vectors += 2;
        if (disp_ready !== 1'b0) begin miscompares++; $display("FAIL full_disp_ready got=%b required=0", disp_ready); end
        if (free_cnt !== 4'd0)   begin miscompares++; $display("FAIL full_free_cnt got=%0d required=0", free_cnt); end
        disp(ADD, 5'd30, 5'd0, 5'd0, 32'd1, 32'd1);
        step();
        idle();
        step();
        vectors += 2;
        if (free_cnt !== 4'd0)  begin miscompares++; $display("FAIL full_ninth_free_cnt got=%0d required=0", free_cnt); end
        if (res_valid !== 1'b0) begin miscompares++; $display("FAIL full_ninth_issued got=%b required=0", res_valid); end
        bcast(0, 5'd25, 32'd100);
        exp_q.push_back({5'd6, 32'd105});
        step();
        idle();
        step();
        vectors += 3;
        if (res_valid !== 1'b1)  begin miscompares++; $display("FAIL full_wake5_valid got=%b required=1", res_valid); end
        if (disp_ready !== 1'b1) begin miscompares++; $display("FAIL full_wake5_disp_ready got=%b required=1", disp_ready); end
        if (free_cnt !== 4'd1)   begin miscompares++; $display("FAIL full_wake5_free_cnt got=%0d required=1", free_cnt); end
        for (int i = 0; i < 8; i++) begin
            if (i != 5) begin
                bcast(0, 5'(20 + i), 32'd50);
                exp_q.push_back({5'(i + 1), 32'(50 + i)});
                step();
            end
        end
        idle();
        drain("full");
    endtask

    task automatic test_age_order();
        disp(ADD, 5'd14, 5'd20, 5'd0, 32'd0, 32'd1); step();
        disp(ADD, 5'd15, 5'd21, 5'd0, 32'd0, 32'd2); step();
        disp(ADD, 5'd16, 5'd22, 5'd0, 32'd0, 32'd3); step();
        disp(SUB, 5'd17, 5'd23, 5'd0, 32'd0, 32'd4);
        bcast(0, 5'd21, 32'd10);
        exp_q.push_back({5'd15, 32'd12});
        step();
        idle();
        step();
        disp(XOR, 5'd18, 5'd0, 5'd0, 32'h0000_00F0, 32'h0000_000F);
        bcast(1, 5'd23, 32'd100);
        exp_q.push_back({5'd17, 32'd96});
        exp_q.push_back({5'd18, 32'h0000_00FF});
        step();
        idle();
        res_ready = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            vectors += 4;
            if (res_valid !== 1'b1)  begin miscompares++; $display("FAIL age_hold_valid c=%0d got=%b required=1", c, res_valid); end
            if (res_tag !== 5'd17)   begin miscompares++; $display("FAIL age_hold_tag c=%0d got=%0d required=17", c, res_tag); end
            if (res_data !== 32'd96) begin miscompares++; $display("FAIL age_hold_data c=%0d got=%h required=60", c, res_data); end
            if (free_cnt !== 4'd5)   begin miscompares++; $display("FAIL age_hold_free_cnt c=%0d got=%0d required=5", c, free_cnt); end
            step();
        end
        res_ready = 1'b1;
        step();
        vectors++;
        if (res_tag !== 5'd18) begin miscompares++; $display("FAIL age_second_tag got=%0d required=18", res_tag); end
        bcast(0, 5'd20, 32'd1);
        exp_q.push_back({5'd14, 32'd2});
        step();
        idle();
        bcast(0, 5'd22, 32'd1);
        exp_q.push_back({5'd16, 32'd4});
        step();
        idle();
        drain("age");
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        disp(ADD, 5'd12, 5'd0, 5'd0, 32'd1, 32'd2); step();
        disp(SUB, 5'd13, 5'd7, 5'd0, 32'd0, 32'd1); step();
        idle();
        vectors++;
        if (res_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_valid got=%b required=1", res_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 4;
        if (res_valid !== 1'b0)  begin miscompares++; $display("FAIL rstmid_res_valid got=%b required=0", res_valid); end
        if (free_cnt !== 4'd8)   begin miscompares++; $display("FAIL rstmid_free_cnt got=%0d required=8", free_cnt); end
        if (disp_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_disp_ready got=%b required=1", disp_ready); end
        if (res_data !== 32'd0)  begin miscompares++; $display("FAIL rstmid_res_data got=%h required=0", res_data); end
        exp_q.delete();
        step(); step();
        rst_n = 1'b1;
        res_ready = 1'b1;
        bcast(0, 5'd7, 32'd9);
        step();
        idle();
        disp(XOR, 5'd19, 5'd0, 5'd0, 32'h1234_5678, 32'hFFFF_0000);
        exp_q.push_back({5'd19, 32'hEDCB_5678});
        step();
        idle();
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_add();
        test_cdb_wakeup();
        test_bypass();
        test_back_to_back();
        test_full();
        test_age_order();
        test_reset_mid();
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
